// File: rtl/kvs_arb_pkg.sv
// kvs_req_arb shared types: op codes, arbiter FSM states, in-flight tag.
// Optional stats outputs are enabled with `define KVS_ARB_STATS_EN.
package kvs_arb_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_INSERT = 2'd1,
        OP_UPDATE = 2'd2,
        OP_DELETE = 2'd3
    } kvs_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MOD  = 1'b1
    } arb_state_e;

    // Tag id field sized for the largest supported client count.
    localparam int MAX_CLIENTS = 16;
    localparam int CID_W       = $clog2(MAX_CLIENTS);

    typedef struct packed {
        logic             pend;
        logic [CID_W-1:0] client_id;
    } tag_t;

endpackage

// File: rtl/kvs_req_arb_if.sv
// Client request/response bundle plus the kvs core port, as seen by
// the arbiter (slave) and by whatever drives it (master).
interface kvs_req_arb_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int KEY_BITS    = 32,
    parameter int VAL_BITS    = 32
);
    logic [NUM_CLIENTS-1:0]          req_valid;
    logic [NUM_CLIENTS-1:0]          req_ready;
    logic [2*NUM_CLIENTS-1:0]        req_op;
    logic [KEY_BITS*NUM_CLIENTS-1:0] req_key;
    logic [VAL_BITS*NUM_CLIENTS-1:0] req_value;
    logic [NUM_CLIENTS-1:0]          rsp_valid;
    logic                            rsp_hit;
    logic [VAL_BITS-1:0]             rsp_value;
    logic                            kvs_insert;
    logic                            kvs_busy;
    logic [KEY_BITS-1:0]             kvs_ins_key;
    logic [VAL_BITS-1:0]             kvs_ins_value;
    logic                            kvs_lookup;
    logic [KEY_BITS-1:0]             kvs_key;
    logic                            kvs_modify;
    logic                            kvs_del;
    logic [VAL_BITS-1:0]             kvs_mod_value;
    logic                            kvs_valid;
    logic [VAL_BITS-1:0]             kvs_res;

    modport master (
        output req_valid, req_op, req_key, req_value,
        output kvs_busy, kvs_valid, kvs_res,
        input  req_ready, rsp_valid, rsp_hit, rsp_value,
        input  kvs_insert, kvs_ins_key, kvs_ins_value,
        input  kvs_lookup, kvs_key,
        input  kvs_modify, kvs_del, kvs_mod_value
    );

    modport slave (
        input  req_valid, req_op, req_key, req_value,
        input  kvs_busy, kvs_valid, kvs_res,
        output req_ready, rsp_valid, rsp_hit, rsp_value,
        output kvs_insert, kvs_ins_key, kvs_ins_value,
        output kvs_lookup, kvs_key,
        output kvs_modify, kvs_del, kvs_mod_value
    );
endinterface

// File: rtl/kvs_req_arb_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting after the
// last winner; pointer moves to the winner when adv_i is strobed.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         adv_i,
    output logic [N-1:0] gnt_o
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr_q, ptr_d;

    // Scan farthest-first so the nearest requester after ptr_q wins last.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        for (int k = N; k >= 1; k--) begin
            for (int i = 0; i < N; i++) begin
                if (req_i[i] && ((int'(ptr_q) + k) % N) == i) begin
                    gnt_o    = '0;
                    gnt_o[i] = 1'b1;
                    ptr_d    = IW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IW'(N - 1);
        end else if (adv_i && |gnt_o) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/kvs_req_arb.sv
// Multi-client round-robin front end for the kvs hashmap core.
// `define KVS_ARB_STATS_EN adds stat_hits/stat_misses counters.
module kvs_req_arb
    import kvs_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int KEY_BITS    = 32,
    parameter int VAL_BITS    = 32,
    parameter int LOOKUP_LAT  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    kvs_req_arb_if.slave  bus
`ifdef KVS_ARB_STATS_EN
    ,
    output logic [31:0]   stat_hits,
    output logic [31:0]   stat_misses
`endif
);
    localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    arb_state_e           state_q, state_d;
    kvs_op_e              op_q, op_d;
    logic [VAL_BITS-1:0]  val_q, val_d;
    tag_t                 tag_q [LOOKUP_LAT];
    tag_t                 tag_out;

    logic [NUM_CLIENTS-1:0] elig, gnt;
    logic                   fire, ins, lk;
    kvs_op_e                win_op;
    logic [KEY_BITS-1:0]    win_key;
    logic [VAL_BITS-1:0]    win_val;
    logic [IW-1:0]          win_id;

    // Inserts are held off while the core is busy; nothing wins in reset.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            elig[i] = rst_n && (state_q == IDLE) && bus.req_valid[i]
                      && !((bus.req_op[2*i +: 2] == OP_INSERT) && bus.kvs_busy);
        end
    end

    rr_arbiter #(.N(NUM_CLIENTS)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (elig),
        .adv_i (fire),
        .gnt_o (gnt)
    );

    always_comb begin
        win_op  = OP_LOOKUP;
        win_key = '0;
        win_val = '0;
        win_id  = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (gnt[i]) begin
                win_op  = kvs_op_e'(bus.req_op[2*i +: 2]);
                win_key = bus.req_key[KEY_BITS*i +: KEY_BITS];
                win_val = bus.req_value[VAL_BITS*i +: VAL_BITS];
                win_id  = IW'(i);
            end
        end
    end

    assign fire = |gnt;
    assign ins  = fire && (win_op == OP_INSERT);
    assign lk   = fire && (win_op != OP_INSERT);

    assign bus.req_ready     = gnt;
    assign bus.kvs_insert    = ins;
    assign bus.kvs_ins_key   = ins ? win_key : '0;
    assign bus.kvs_ins_value = ins ? win_val : '0;
    assign bus.kvs_lookup    = lk;
    assign bus.kvs_key       = lk ? win_key : '0;
    assign bus.kvs_modify    = (state_q == MOD) && (op_q == OP_UPDATE);
    assign bus.kvs_del       = (state_q == MOD) && (op_q == OP_DELETE);
    assign bus.kvs_mod_value = (state_q == MOD) ? val_q : '0;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        val_d   = val_q;
        unique case (state_q)
            IDLE: begin
                if (lk && (win_op == OP_UPDATE || win_op == OP_DELETE)) begin
                    state_d = MOD;
                    op_d    = win_op;
                    val_d   = win_val;
                end
            end
            MOD:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_LOOKUP;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            val_q   <= val_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LOOKUP_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0].pend      <= lk;
            tag_q[0].client_id <= CID_W'(win_id);
            for (int i = 1; i < LOOKUP_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign tag_out = tag_q[LOOKUP_LAT-1];

    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            bus.rsp_valid[i] = tag_out.pend && (tag_out.client_id == CID_W'(i));
        end
    end

    assign bus.rsp_hit   = tag_out.pend && bus.kvs_valid;
    assign bus.rsp_value = tag_out.pend ? bus.kvs_res : '0;

`ifdef KVS_ARB_STATS_EN
    logic [31:0] hits_q, misses_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (tag_out.pend) begin
            if (bus.kvs_valid) hits_q   <= hits_q + 32'd1;
            else               misses_q <= misses_q + 32'd1;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_kvs_req_arb.sv
// Randomized bench for kvs_req_arb with a transaction-level arbiter
// model and a small kvs core model (key map + fixed-latency replies).
module tb_kvs_req_arb;
    localparam int N   = 4;
    localparam int KB  = 32;
    localparam int VB  = 32;
    localparam int LAT = 4;
    localparam int NCYC = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    kvs_req_arb_if #(.NUM_CLIENTS(N), .KEY_BITS(KB), .VAL_BITS(VB)) bus ();

`ifdef KVS_ARB_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    kvs_req_arb #(
        .NUM_CLIENTS (N),
        .KEY_BITS    (KB),
        .VAL_BITS    (VB),
        .LOOKUP_LAT  (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave)
`ifdef KVS_ARB_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    typedef struct {
        int          due;
        int          cid;
        bit          hit;
        logic [31:0] val;
        bit          live;
    } ent_t;

    int tests = 0;
    int fails = 0;

    int          cyc;
    int          ptr;
    bit          mod_pend;
    int          mod_op;
    logic [31:0] mod_key, mod_val;
    int          hits, misses;
    logic [31:0] kv [logic [31:0]];
    ent_t        pq [$];

    bit          rv   [N];
    int          rop  [N];
    logic [31:0] rkey [N];
    logic [31:0] rval [N];
    bit          busy;
    logic [31:0] kres;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            rv[i]   = ($urandom_range(99) < 50);
            rop[i]  = $urandom_range(3);
            rkey[i] = $urandom_range(7);
            rval[i] = $urandom;
        end
        busy = ($urandom_range(3) == 0);
        if (cyc == 997) begin
            for (int i = 0; i < N; i++) rv[i] = 1'b0;
        end
        if (cyc == 998) begin
            for (int i = 0; i < N; i++) rv[i] = (i == 0);
            rop[0] = 0;
        end
        if (cyc >= 1002 && cyc < 1010) begin
            for (int i = 0; i < N; i++) begin
                rv[i]  = 1'b1;
                rop[i] = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]          = rv[i];
            bus.req_op[2*i +: 2]      = 2'(rop[i]);
            bus.req_key[KB*i +: KB]   = rkey[i];
            bus.req_value[VB*i +: VB] = rval[i];
        end
        bus.kvs_busy = busy;
        kres = $urandom;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            bus.kvs_valid = pq[0].hit;
            if (pq[0].hit) kres = pq[0].val;
        end else begin
            bus.kvs_valid = 1'($urandom_range(1));
        end
        bus.kvs_res = kres;
    endtask

    task automatic step();
        int          win;
        logic [N-1:0] e_rdy, e_rv;
        bit          e_ins, e_lk, e_mod, e_del, e_hit, due;
        logic [31:0] e_ik, e_iv, e_k, e_mv, e_val;
        ent_t        e;

        rst_n = !(cyc < 2 || cyc == 1000 || cyc == 1001);
        drive();
        #1;
        win = -1;
        e_rdy = '0; e_ins = 0; e_ik = '0; e_iv = '0; e_lk = 0; e_k = '0;
        e_mod = 0; e_del = 0; e_mv = '0;
        if (rst_n) begin
            if (mod_pend) begin
                e_mod = (mod_op == 2);
                e_del = (mod_op == 3);
                e_mv  = mod_val;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (ptr + k) % N;
                    if (win < 0 && rv[c] && !(rop[c] == 1 && busy)) win = c;
                end
                if (win >= 0) begin
                    e_rdy = N'(1) << win;
                    if (rop[win] == 1) begin
                        e_ins = 1; e_ik = rkey[win]; e_iv = rval[win];
                    end else begin
                        e_lk = 1; e_k = rkey[win];
                    end
                end
            end
        end
        due = (pq.size() > 0 && pq[0].due == cyc);
        e_rv = '0; e_hit = 0; e_val = '0;
        if (rst_n && due && pq[0].live) begin
            e_rv  = N'(1) << pq[0].cid;
            e_hit = pq[0].hit;
            e_val = kres;
        end

        check("req_ready", 64'(bus.req_ready), 64'(e_rdy));
        check("kvs_insert", 64'(bus.kvs_insert), 64'(e_ins));
        check("kvs_ins_key", 64'(bus.kvs_ins_key), 64'(e_ik));
        check("kvs_ins_value", 64'(bus.kvs_ins_value), 64'(e_iv));
        check("kvs_lookup", 64'(bus.kvs_lookup), 64'(e_lk));
        check("kvs_key", 64'(bus.kvs_key), 64'(e_k));
        check("kvs_modify", 64'(bus.kvs_modify), 64'(e_mod));
        check("kvs_del", 64'(bus.kvs_del), 64'(e_del));
        check("kvs_mod_value", 64'(bus.kvs_mod_value), 64'(e_mv));
        check("rsp_valid", 64'(bus.rsp_valid), 64'(e_rv));
        check("rsp_hit", 64'(bus.rsp_hit), 64'(e_hit));
        check("rsp_value", 64'(bus.rsp_value), 64'(e_val));
`ifdef KVS_ARB_STATS_EN
        check("stat_hits", 64'(stat_hits), rst_n ? 64'(hits) : 64'd0);
        check("stat_misses", 64'(stat_misses), rst_n ? 64'(misses) : 64'd0);
`endif

        if (!rst_n) begin
            ptr = N - 1;
            mod_pend = 0;
            hits = 0;
            misses = 0;
            foreach (pq[i]) pq[i].live = 0;
        end else begin
            if (due && pq[0].live) begin
                if (pq[0].hit) hits++;
                else           misses++;
            end
            if (mod_pend) begin
                if (mod_op == 2 && kv.exists(mod_key)) kv[mod_key] = mod_val;
                if (mod_op == 3 && kv.exists(mod_key)) kv.delete(mod_key);
                mod_pend = 0;
            end else if (win >= 0) begin
                ptr = win;
                if (rop[win] == 1) begin
                    kv[rkey[win]] = rval[win];
                end else begin
                    e.due  = cyc + LAT;
                    e.cid  = win;
                    e.hit  = kv.exists(rkey[win]);
                    e.val  = e.hit ? kv[rkey[win]] : 32'd0;
                    e.live = 1;
                    pq.push_back(e);
                    if (rop[win] >= 2) begin
                        mod_pend = 1;
                        mod_op   = rop[win];
                        mod_key  = rkey[win];
                        mod_val  = rval[win];
                    end
                end
            end
        end
        if (due) void'(pq.pop_front());
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        cyc = 0;
        ptr = N - 1;
        mod_pend = 0;
        mod_op = 0;
        mod_key = '0;
        mod_val = '0;
        hits = 0;
        misses = 0;
        bus.req_valid = '0;
        bus.req_op = '0;
        bus.req_key = '0;
        bus.req_value = '0;
        bus.kvs_busy = 1'b0;
        bus.kvs_valid = 1'b0;
        bus.kvs_res = '0;
        @(posedge clk);
        #1;
        while (cyc < NCYC) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
